// File: rtl/dmem_arbiter_pkg.sv
// Purpose: shared encodings and default widths for the data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 32;

    // Which requester the read data returning next cycle belongs to.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } owner_t;

    typedef enum logic {
        ARB_IDLE     = 1'b0,
        ARB_DBG_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Purpose: requester-side bundle for the core and debug ports of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/addr/wdata until their gnt is seen.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic              cpu_req;
    logic [DW/8-1:0]   cpu_wren;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DW-1:0]     cpu_rdata;

    logic              dbg_req;
    logic              dbg_lock;
    logic [DW/8-1:0]   dbg_wren;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DW-1:0]     dbg_rdata;

    // Requesters drive requests and observe grants/read returns.
    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        output dbg_req, dbg_lock, dbg_wren, dbg_addr, dbg_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata
    );

    // The arbiter sees requests and produces grants/read returns.
    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_lock, dbg_wren, dbg_addr, dbg_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Purpose: saturating count of consecutive cycles the debug port waited ungranted.
// Latency: at_max is registered state, usable combinationally in the same cycle.
// Backpressure: none; clears on any grant or when the requester stops waiting.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic granted,
    output logic at_max
);

    localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

    logic [3:0] cnt;

    // Count denied cycles, stop at the limit, clear once served or withdrawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (granted || !waiting) begin
            cnt <= 4'd0;
        end else if (cnt != MAX_C) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: shares the byte-lane data memory between core (priority) and debug (starve-bounded, lockable).
// Latency: grant is combinational; read data returns one cycle after the read grant.
// Backpressure: ungranted core request raises cpu_stall; optional DMEM_ARB_PERF_CNT_EN adds perf counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic               sysclk,
    input  logic               rstd,
    dmem_arbiter_if.slave      bus,
    output logic [AW-1:0]      mem_addr,
    output logic [DW/8-1:0]    mem_wren,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        dbg_acc_cnt
`endif
);

    arb_state_t     state;
    arb_state_t     state_nxt;
    owner_t         rd_owner;
    logic           cpu_gnt;
    logic           dbg_gnt;
    logic           at_max;
    logic [DW-1:0]  cpu_rdata_q;
    logic [DW-1:0]  dbg_rdata_q;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (sysclk),
        .rst_n   (rstd),
        .waiting (bus.dbg_req),
        .granted (dbg_gnt),
        .at_max  (at_max)
    );

    // State register.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enter lock on a locked debug grant; leave when the debug port drops lock.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:     if (dbg_gnt && bus.dbg_lock) state_nxt = ARB_DBG_LOCK;
            ARB_DBG_LOCK: if (!bus.dbg_lock)           state_nxt = ARB_IDLE;
            default:                                   state_nxt = ARB_IDLE;
        endcase
    end

    // Grants: starved debug first, then core, then debug; locked state serves debug only.
    // Gated by reset so grants drop the instant reset is applied.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rstd) begin
            case (state)
                ARB_IDLE: begin
                    if (bus.dbg_req && at_max) dbg_gnt = 1'b1;
                    else if (bus.cpu_req)      cpu_gnt = 1'b1;
                    else if (bus.dbg_req)      dbg_gnt = 1'b1;
                end
                ARB_DBG_LOCK: dbg_gnt = bus.dbg_req;
                default: ;
            endcase
        end
    end

    // Memory side carries the granted requester's access, all-zero when idle.
    always_comb begin
        mem_addr  = '0;
        mem_wren  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = bus.cpu_addr;
            mem_wren  = bus.cpu_wren;
            mem_wdata = bus.cpu_wdata;
        end else if (dbg_gnt) begin
            mem_addr  = bus.dbg_addr;
            mem_wren  = bus.dbg_wren;
            mem_wdata = bus.dbg_wdata;
        end
    end

    // Remember who issued a read so next cycle's memory data is steered to it.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            rd_owner <= NONE;
        end else if (cpu_gnt && (bus.cpu_wren == '0)) begin
            rd_owner <= CPU;
        end else if (dbg_gnt && (bus.dbg_wren == '0)) begin
            rd_owner <= DBG;
        end else begin
            rd_owner <= NONE;
        end
    end

    // Capture returned words so each port's rdata holds between its own reads.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (rd_owner == CPU) cpu_rdata_q <= mem_rdata;
            if (rd_owner == DBG) dbg_rdata_q <= mem_rdata;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.cpu_stall  = rstd & bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rvalid = (rd_owner == CPU);
    assign bus.dbg_rvalid = (rd_owner == DBG);
    assign bus.cpu_rdata  = (rd_owner == CPU) ? mem_rdata : cpu_rdata_q;
    assign bus.dbg_rdata  = (rd_owner == DBG) ? mem_rdata : dbg_rdata_q;

`ifdef DMEM_ARB_PERF_CNT_EN
    // Free-running, wrapping counts of core stall cycles and debug accesses.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            stall_cnt   <= 32'd0;
            dbg_acc_cnt <= 32'd0;
        end else begin
            if (bus.cpu_stall) stall_cnt   <= stall_cnt + 32'd1;
            if (dbg_gnt)       dbg_acc_cnt <= dbg_acc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed self-checking bench for dmem_arbiter with a registered-read memory model.
// Latency: inputs change on the falling edge, outputs are sampled 1 time unit later.
// Backpressure: core/debug requests are held until granted, as a real requester would.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk  = 1'b0;
    logic rstd = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    logic [7:0]  mem_addr;
    logic [3:0]  mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] dbg_acc_cnt;
`endif

    dmem_arbiter dut (
        .sysclk    (clk),
        .rstd      (rstd),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .dbg_acc_cnt (dbg_acc_cnt)
`endif
    );

    // Byte-lane memory with registered read; preload port for initial contents.
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'd0;
    logic [31:0] pl_data = 32'd0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (pl_en) mem[pl_addr] <= pl_data;
        for (int i = 0; i < 4; i++)
            if (mem_wren[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_set(input logic req, input logic [3:0] wren, input logic [7:0] addr,
                           input logic [31:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_wren  = wren;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic dbg_set(input logic req, input logic lock, input logic [3:0] wren,
                           input logic [7:0] addr, input logic [31:0] wdata);
        bus.dbg_req   = req;
        bus.dbg_lock  = lock;
        bus.dbg_wren  = wren;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    initial begin
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        dbg_set(0, 0, 4'h0, 8'h00, 32'h0);

        // Preload while in reset.
        @(negedge clk);
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h05, 32'h00000000);
        preload(8'h01, 32'h01010101);
        preload(8'h02, 32'h02020202);

        // Reset state, with a core request present.
        cpu_set(1, 4'h0, 8'h10, 32'h0);
        #1;
        check("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
        check("rst_dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        check("rst_cpu_stall",  32'(bus.cpu_stall),  32'd0);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("rst_cpu_rdata",  bus.cpu_rdata,       32'd0);
        check("rst_dbg_rdata",  bus.dbg_rdata,       32'd0);
        check("rst_mem_wren",   32'(mem_wren),       32'd0);
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        @(negedge clk);
        rstd = 1'b1;

        // Core alone: read 0x10.
        @(negedge clk);
        cpu_set(1, 4'h0, 8'h10, 32'h0);
        #1;
        check("core_gnt",      32'(bus.cpu_gnt),   32'd1);
        check("core_stall",    32'(bus.cpu_stall), 32'd0);
        check("core_mem_addr", 32'(mem_addr),      32'h10);
        @(negedge clk);
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        #1;
        check("core_rvalid",   32'(bus.cpu_rvalid), 32'd1);
        check("core_rdata",    bus.cpu_rdata,       32'hDEADBEEF);
        check("core_dbg_rv",   32'(bus.dbg_rvalid), 32'd0);
        @(negedge clk);
        #1;
        check("core_rvalid_1", 32'(bus.cpu_rvalid), 32'd0);
        check("core_rdata_hold", bus.cpu_rdata,     32'hDEADBEEF);

        // Byte lanes: write lane 1 only into a zero word, then read back.
        @(negedge clk);
        cpu_set(1, 4'b0010, 8'h05, 32'hAABBCCDD);
        #1;
        check("lane_gnt",   32'(bus.cpu_gnt), 32'd1);
        check("lane_wren",  32'(mem_wren),    32'h2);
        check("lane_wdata", mem_wdata,        32'hAABBCCDD);
        @(negedge clk);
        cpu_set(1, 4'h0, 8'h05, 32'h0);
        #1;
        check("lane_wr_no_rv", 32'(bus.cpu_rvalid), 32'd0);
        @(negedge clk);
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        #1;
        check("lane_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("lane_rdata",  bus.cpu_rdata,       32'h0000CC00);

        // Alternating reads: core addr 1, then debug addr 2.
        @(negedge clk);
        cpu_set(1, 4'h0, 8'h01, 32'h0);
        #1;
        check("alt_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        @(negedge clk);
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        dbg_set(1, 0, 4'h0, 8'h02, 32'h0);
        #1;
        check("alt_dbg_gnt",  32'(bus.dbg_gnt),    32'd1);
        check("alt_cpu_rv",   32'(bus.cpu_rvalid), 32'd1);
        check("alt_dbg_rv0",  32'(bus.dbg_rvalid), 32'd0);
        check("alt_cpu_data", bus.cpu_rdata,       32'h01010101);
        @(negedge clk);
        dbg_set(0, 0, 4'h0, 8'h00, 32'h0);
        #1;
        check("alt_cpu_rv1",   32'(bus.cpu_rvalid), 32'd0);
        check("alt_dbg_rv",    32'(bus.dbg_rvalid), 32'd1);
        check("alt_dbg_data",  bus.dbg_rdata,       32'h02020202);
        check("alt_cpu_hold",  bus.cpu_rdata,       32'h01010101);

        // Contention: both requesting continuously; debug wins every 5th cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cpu_set(1, 4'hF, 8'h30, 32'h5555AAAA);
                dbg_set(1, 0, 4'h0, 8'h10, 32'h0);
            end
            #1;
            check($sformatf("cont_cpu_gnt_%0d", i),   32'(bus.cpu_gnt),   32'((i % 5) != 4));
            check($sformatf("cont_dbg_gnt_%0d", i),   32'(bus.dbg_gnt),   32'((i % 5) == 4));
            check($sformatf("cont_cpu_stall_%0d", i), 32'(bus.cpu_stall), 32'((i % 5) == 4));
            if (i == 5) begin
                check("cont_dbg_rv",   32'(bus.dbg_rvalid), 32'd1);
                check("cont_dbg_data", bus.dbg_rdata,       32'hDEADBEEF);
            end
        end
        @(negedge clk);
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        dbg_set(0, 0, 4'h0, 8'h00, 32'h0);

        // Lock burst: debug starves for 4 cycles, then writes 0..3 back to back.
        @(negedge clk);
        cpu_set(1, 4'h0, 8'h10, 32'h0);
        dbg_set(1, 1, 4'hF, 8'h00, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("lock_pre_cpu_%0d", i), 32'(bus.cpu_gnt), 32'd1);
            check($sformatf("lock_pre_dbg_%0d", i), 32'(bus.dbg_gnt), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_set(1, (k < 3), 4'hF, 8'(k), 32'h11223344);
            #1;
            check($sformatf("lock_dbg_gnt_%0d", k), 32'(bus.dbg_gnt),   32'd1);
            check($sformatf("lock_cpu_gnt_%0d", k), 32'(bus.cpu_gnt),   32'd0);
            check($sformatf("lock_stall_%0d", k),   32'(bus.cpu_stall), 32'd1);
            check($sformatf("lock_addr_%0d", k),    32'(mem_addr),      32'(k));
            @(negedge clk);
        end
        dbg_set(0, 0, 4'h0, 8'h00, 32'h0);
        #1;
        check("lock_cpu_resume", 32'(bus.cpu_gnt), 32'd1);
        @(negedge clk);
        cpu_set(1, 4'h0, 8'h02, 32'h0);
        @(negedge clk);
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        dbg_set(1, 0, 4'h0, 8'h03, 32'h0);
        #1;
        check("lock_rb_cpu_rv",   32'(bus.cpu_rvalid), 32'd1);
        check("lock_rb_cpu_data", bus.cpu_rdata,       32'h11223344);
        check("lock_rb_dbg_gnt",  32'(bus.dbg_gnt),    32'd1);
        @(negedge clk);
        dbg_set(0, 0, 4'h0, 8'h00, 32'h0);
        #1;
        check("lock_rb_dbg_rv",   32'(bus.dbg_rvalid), 32'd1);
        check("lock_rb_dbg_data", bus.dbg_rdata,       32'h11223344);

        // Reset mid-lock with a debug read outstanding.
        @(negedge clk);
        dbg_set(1, 1, 4'h0, 8'h10, 32'h0);
        #1;
        check("rl_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        @(negedge clk);
        dbg_set(0, 1, 4'h0, 8'h00, 32'h0);
        cpu_set(1, 4'h0, 8'h01, 32'h0);
        #1;
        check("rl_hold_dbg_gnt", 32'(bus.dbg_gnt),    32'd0);
        check("rl_hold_cpu_gnt", 32'(bus.cpu_gnt),    32'd0);
        check("rl_hold_stall",   32'(bus.cpu_stall),  32'd1);
        check("rl_hold_wren",    32'(mem_wren),       32'd0);
        check("rl_hold_addr",    32'(mem_addr),       32'd0);
        check("rl_hold_dbg_rv",  32'(bus.dbg_rvalid), 32'd1);
        @(negedge clk);
        dbg_set(1, 1, 4'h0, 8'h02, 32'h0);
        #1;
        check("rl_rd_gnt", 32'(bus.dbg_gnt), 32'd1);
        @(posedge clk);
        #2;
        check("rl_pending_rv", 32'(bus.dbg_rvalid), 32'd1);
        rstd = 1'b0;
        #1;
        check("rl_rst_dbg_rv",   32'(bus.dbg_rvalid), 32'd0);
        check("rl_rst_dbg_data", bus.dbg_rdata,       32'd0);
        check("rl_rst_cpu_data", bus.cpu_rdata,       32'd0);
        check("rl_rst_cpu_gnt",  32'(bus.cpu_gnt),    32'd0);
        check("rl_rst_dbg_gnt",  32'(bus.dbg_gnt),    32'd0);
        check("rl_rst_stall",    32'(bus.cpu_stall),  32'd0);
        check("rl_rst_wren",     32'(mem_wren),       32'd0);
        check("rl_rst_addr",     32'(mem_addr),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rstd = 1'b1;
        dbg_set(0, 0, 4'h0, 8'h00, 32'h0);
        cpu_set(1, 4'h0, 8'h01, 32'h0);
        #1;
        check("post_rst_cpu_gnt", 32'(bus.cpu_gnt),    32'd1);
        check("post_rst_dbg_rv",  32'(bus.dbg_rvalid), 32'd0);
        @(negedge clk);
        cpu_set(0, 4'h0, 8'h00, 32'h0);
        #1;
        check("post_rst_cpu_rv",   32'(bus.cpu_rvalid), 32'd1);
        check("post_rst_cpu_data", bus.cpu_rdata,       32'h11223344);
        check("post_rst_dbg_rv1",  32'(bus.dbg_rvalid), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
